// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder with programmable fetch latency
//
// Purpose: serves fetch-stage requests from a local word-addressed instruction
// store. A held request is accepted, counted down for LATENCY edges (stretched
// by i_hold, restarted by an address redirect) and answered with a one-cycle
// acknowledge. Misaligned or out-of-range fetches are flagged and answered
// with a NOP. A side write port fills the store.
//
// Ports:
//   i_clk            rising-edge clock
//   i_rst            synchronous active-high reset
//   i_inst_req       fetch request, held with a stable address
//   i_inst_req_addr  byte address of the requested instruction
//   i_hold           stall: freezes acceptance and the latency counter
//   i_load_we        store write enable
//   i_load_addr      store word index for the write
//   i_load_data      store write data
//   or_inst_data     returned instruction, valid while or_inst_ack is high
//   or_inst_ack      one-cycle acknowledge pulse
//   or_inst_err      misaligned / out-of-range flag, with or_inst_ack
//   or_busy          high while a fetch is in flight or being answered
module imem_responder #(
   parameter int  XLEN        = 32,
   parameter int  DEPTH_WORDS = 1024,
   parameter int  LATENCY     = 2,
   localparam int ADDR_BITS   = $clog2(DEPTH_WORDS)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_inst_req,
   input  logic [XLEN-1:0]      i_inst_req_addr,
   input  logic                 i_hold,
   input  logic                 i_load_we,
   input  logic [ADDR_BITS-1:0] i_load_addr,
   input  logic [31:0]          i_load_data,
   output logic [31:0]          or_inst_data,
   output logic                 or_inst_ack,
   output logic                 or_inst_err,
   output logic                 or_busy
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

   state_t          state;
   logic [3:0]      cnt;
   logic [XLEN-1:0] addr_q;
   logic [31:0]     store [DEPTH_WORDS];

   logic [ADDR_BITS-1:0] word_idx;
   logic                 fetch_err;
   logic [31:0]          fetch_data;

   // Response is always formed from the latched address; at the read edge it
   // equals the live address because a mismatch is handled as a redirect first.
   always_comb begin
      word_idx   = addr_q[ADDR_BITS+1:2];
      fetch_err  = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_BITS + 2)) != '0);
      fetch_data = fetch_err ? NOP : store[word_idx];
   end

   // Store is not reset; a same-edge write and read returns the old word
   // because the read above samples the array before this update lands.
   always_ff @(posedge i_clk) begin
      if (i_load_we) begin
         store[i_load_addr] <= i_load_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= IDLE;
         cnt          <= '0;
         addr_q       <= '0;
         or_inst_data <= '0;
         or_inst_ack  <= 1'b0;
         or_inst_err  <= 1'b0;
         or_busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_inst_req && !i_hold) begin
                  addr_q  <= i_inst_req_addr;
                  cnt     <= CNT_LOAD;
                  state   <= BUSY;
                  or_busy <= 1'b1;
               end
            end
            BUSY: begin
               if (!i_inst_req) begin
                  state   <= IDLE;
                  or_busy <= 1'b0;
               end else if (i_inst_req_addr != addr_q) begin
                  addr_q <= i_inst_req_addr;
                  cnt    <= CNT_LOAD;
               end else if (i_hold) begin
                  // stalled: counter frozen
               end else if (cnt == 4'd0) begin
                  state        <= RESP;
                  or_inst_ack  <= 1'b1;
                  or_inst_err  <= fetch_err;
                  or_inst_data <= fetch_data;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               // no request is sampled here; the requester re-raises next cycle
               state       <= IDLE;
               or_inst_ack <= 1'b0;
               or_inst_err <= 1'b0;
               or_busy     <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - self-checking bench for imem_responder
module tb_imem_responder;

   localparam int XLEN      = 32;
   localparam int DEPTH     = 1024;
   localparam int LATENCY   = 3;
   localparam int ADDR_BITS = 10;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic                 i_clk = 1'b0;
   logic                 i_rst = 1'b1;
   logic                 i_inst_req = 1'b0;
   logic [XLEN-1:0]      i_inst_req_addr = '0;
   logic                 i_hold = 1'b0;
   logic                 i_load_we = 1'b0;
   logic [ADDR_BITS-1:0] i_load_addr = '0;
   logic [31:0]          i_load_data = '0;
   logic [31:0]          or_inst_data;
   logic                 or_inst_ack;
   logic                 or_inst_err;
   logic                 or_busy;

   imem_responder #(
      .XLEN(XLEN), .DEPTH_WORDS(DEPTH), .LATENCY(LATENCY)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_inst_req(i_inst_req),
      .i_inst_req_addr(i_inst_req_addr), .i_hold(i_hold),
      .i_load_we(i_load_we), .i_load_addr(i_load_addr), .i_load_data(i_load_data),
      .or_inst_data(or_inst_data), .or_inst_ack(or_inst_ack),
      .or_inst_err(or_inst_err), .or_busy(or_busy)
   );

   always #5 i_clk = ~i_clk;

   logic [31:0] mem [DEPTH];
   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   int last_ack_cyc = 0;

   task automatic step();
      @(posedge i_clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic load(input int idx, input logic [31:0] data);
      i_load_we   = 1'b1;
      i_load_addr = ADDR_BITS'(idx);
      i_load_data = data;
      step();
      i_load_we = 1'b0;
      mem[idx] = data;
   endtask

   // Full fetch: accept, optional stall window, optional write on the read edge.
   task automatic fetch(input logic [31:0] addr, input int hold_after, input int hold_len,
                        input bit wr_at_read, input logic [31:0] wr_data, input string tag);
      logic        exp_err;
      logic [31:0] exp_data;
      int          idx;
      int          k;
      bit          got;
      exp_err  = (addr % 4 != 0) || (addr >= 32'(DEPTH * 4));
      idx      = int'((addr / 4) % DEPTH);
      exp_data = exp_err ? NOP : mem[idx];
      i_inst_req      = 1'b1;
      i_inst_req_addr = addr;
      step();
      chk({tag, ":busy"}, 32'(or_busy), 32'd1);
      got = 1'b0;
      k   = 0;
      while (!got && k < 64) begin
         i_hold = (k >= hold_after) && (k < hold_after + hold_len);
         if (wr_at_read && k == LATENCY + hold_len - 1) begin
            i_load_we   = 1'b1;
            i_load_addr = ADDR_BITS'(idx);
            i_load_data = wr_data;
         end
         step();
         k++;
         i_hold    = 1'b0;
         i_load_we = 1'b0;
         if (or_inst_ack === 1'b1) got = 1'b1;
      end
      if (wr_at_read) mem[idx] = wr_data;
      chk({tag, ":latency"}, 32'(k), 32'(LATENCY + hold_len));
      chk({tag, ":data"}, or_inst_data, exp_data);
      chk({tag, ":err"}, 32'(or_inst_err), 32'(exp_err));
      last_ack_cyc = cyc;
      i_inst_req = 1'b0;
      step();
      chk({tag, ":ack_width"}, 32'(or_inst_ack), 32'd0);
      chk({tag, ":data_hold"}, or_inst_data, exp_data);
   endtask

   task automatic no_ack(input int n, input string tag);
      int acks;
      acks = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (or_inst_ack === 1'b1) acks++;
      end
      chk(tag, 32'(acks), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, k, acks, r;
      logic [31:0] a;
      bit got;

      // reset state
      step();
      step();
      i_rst = 1'b0;
      chk("rst:ack", 32'(or_inst_ack), 32'd0);
      chk("rst:err", 32'(or_inst_err), 32'd0);
      chk("rst:data", or_inst_data, 32'd0);
      chk("rst:busy", 32'(or_busy), 32'd0);

      for (int i = 0; i < DEPTH; i++) load(i, $urandom);

      // single fetch
      load(2, 32'hDEADBEEF);
      fetch(32'h8, 0, 0, 1'b0, 0, "single");

      // back-to-back, LATENCY+2 apart
      load(0, 32'h00000093);
      load(1, 32'h00100113);
      load(2, 32'h00200193);
      fetch(32'h0, 0, 0, 1'b0, 0, "b2b0");
      t0 = last_ack_cyc;
      fetch(32'h4, 0, 0, 1'b0, 0, "b2b1");
      t1 = last_ack_cyc;
      chk("b2b:gap01", 32'(t1 - t0), 32'(LATENCY + 2));
      fetch(32'h8, 0, 0, 1'b0, 0, "b2b2");
      chk("b2b:gap12", 32'(last_ack_cyc - t1), 32'(LATENCY + 2));

      // redirect after one BUSY cycle
      i_inst_req = 1'b1;
      i_inst_req_addr = 32'h10;
      step();
      step();
      i_inst_req_addr = 32'h40;
      k = 0;
      got = 1'b0;
      acks = 0;
      while (!got && k < 64) begin
         step();
         k++;
         if (or_inst_ack === 1'b1) got = 1'b1;
      end
      chk("redir:latency", 32'(k), 32'(LATENCY + 1));
      chk("redir:data", or_inst_data, mem[16]);
      i_inst_req = 1'b0;
      no_ack(LATENCY + 4, "redir:single_ack");

      // withdraw mid-BUSY
      i_inst_req = 1'b1;
      i_inst_req_addr = 32'h20;
      step();
      step();
      i_inst_req = 1'b0;
      step();
      chk("withdraw:busy", 32'(or_busy), 32'd0);
      no_ack(LATENCY + 4, "withdraw:no_ack");

      // hold for 4 BUSY cycles
      fetch(32'h30, 1, 4, 1'b0, 0, "hold4");

      // error responses
      fetch(32'h6, 0, 0, 1'b0, 0, "misalign");
      fetch(32'(DEPTH * 4), 0, 0, 1'b0, 0, "range");

      // same-edge write/read returns the old word, then the new one
      load(5, 32'h11111111);
      fetch(32'h14, 0, 0, 1'b1, 32'h22222222, "rbw_old");
      fetch(32'h14, 0, 0, 1'b0, 0, "rbw_new");

      // reset mid-BUSY for 2 cycles
      i_inst_req = 1'b1;
      i_inst_req_addr = 32'h8;
      step();
      step();
      i_rst = 1'b1;
      step();
      step();
      i_rst = 1'b0;
      i_inst_req = 1'b0;
      chk("midrst:ack", 32'(or_inst_ack), 32'd0);
      chk("midrst:err", 32'(or_inst_err), 32'd0);
      chk("midrst:data", or_inst_data, 32'd0);
      chk("midrst:busy", 32'(or_busy), 32'd0);
      no_ack(LATENCY + 4, "midrst:no_ack");

      // randomized fetches against the shadow store
      for (int n = 0; n < 24; n++) begin
         r = $urandom_range(0, 3);
         if (r <= 1)      a = {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
         else if (r == 2) a = {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
         else             a = $urandom | 32'h0000_1000;
         if ($urandom_range(0, 1) == 1) load($urandom_range(0, DEPTH - 1), $urandom);
         fetch(a, $urandom_range(0, LATENCY - 1), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), $urandom, "rand");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder serving the fetch stage's request/acknowledge interface. It accepts a fetch request (address held with request high), looks up a 32-bit word in a local word-addressed instruction store after a programmable latency, and returns the word with a one-cycle acknowledge pulse. A side write port lets a loader fill the store. Out-of-range or misaligned fetches are flagged and answered with a NOP.

## Interface
- XLEN, 32, address width of the fetch request.
- DEPTH_WORDS, 1024, store depth in 32-bit words (power of two); ADDR_BITS = log2(DEPTH_WORDS).
- LATENCY, 2, cycles from request acceptance to acknowledge (legal range 1..15).
- i_clk  input  1  CPU clock; all logic on the rising edge.
- i_rst  input  1  reset, synchronous and active-high.
- i_inst_req  input  1  fetch request; held high with a stable address until acknowledged or withdrawn.
- i_inst_req_addr  input  XLEN  byte address of the requested instruction.
- i_hold  input  1  external memory stall; freezes acceptance and the latency counter.
- i_load_we  input  1  store write enable.
- i_load_addr  input  ADDR_BITS  store word index for the write.
- i_load_data  input  32  store write data.
- or_inst_data  output  32  returned instruction; valid only while or_inst_ack is high.
- or_inst_ack  output  1  one-cycle acknowledge pulse.
- or_inst_err  output  1  high with or_inst_ack when the fetch was misaligned or out of range.
- or_busy  output  1  high in BUSY or RESP.

## Operation
- States: IDLE, BUSY, RESP. Reset: state IDLE, counter 0, latched address 0, or_inst_data 0, or_inst_ack 0, or_inst_err 0, or_busy 0. The store contents are not reset.
- IDLE: at an edge where i_inst_req=1 and i_hold=0, latch the address, load counter = LATENCY-1, and go to BUSY. Otherwise stay in IDLE.
- BUSY, checks in priority order:
  - i_inst_req=0: the request is withdrawn. Go to IDLE and issue no ack.
  - i_inst_req_addr differs from the latched address: the fetch redirected on a jump. Relatch the address, reload counter = LATENCY-1, and stay in BUSY.
  - i_hold=1: freeze the counter.
  - counter=0: register the response and go to RESP.
  - Otherwise: decrement the counter.
- Response: err = (addr[1:0]≠0) or (addr[XLEN-1:ADDR_BITS+2]≠0). If err=1, data = 32'h00000013 (NOP). Otherwise data = store[addr[ADDR_BITS+1:2]].
- RESP: or_inst_ack=1, or_inst_err=err, and or_inst_data holds the data for exactly one cycle. Unconditionally go to IDLE. Do not sample a request in this cycle.
- All outputs are registered. Outside RESP, or_inst_ack=0, or_inst_err=0, and or_inst_data holds its last value.
- Store write: occurs at any edge where i_load_we=1, independent of state. If a write and the BUSY→RESP read hit the same word on the same edge, the response returns the old word (read-before-write).
- i_rst=1 in any state forces the reset values on the next edge, including mid-BUSY and during RESP. No ack is produced for an aborted request.

## Timing
- Accept edge = edge N, where IDLE samples req. Ack is high in the cycle after edge N+LATENCY, i.e. LATENCY edges after acceptance. LATENCY=1 gives ack one cycle after the accept cycle.
- Each cycle with i_hold=1 in BUSY adds one cycle. A redirect restarts the full LATENCY from the redirect edge.
- The requester drops req in the ack cycle and re-raises it the following cycle. IDLE accepts on the next edge. Back-to-back throughput is one instruction per LATENCY+2 cycles.
- The counter is 4 bits and never wraps; decrement occurs only when it is nonzero.

## Test plan
- Reset: assert i_rst for 2 cycles mid-BUSY -> the next cycle shows state IDLE, or_inst_ack=0, or_inst_err=0, or_inst_data=0, or_busy=0, and no ack follows.
- Single fetch, LATENCY=3: load store[2]=32'hDEADBEEF, then req addr 0x8 -> ack exactly 3 edges after acceptance, data 32'hDEADBEEF, err=0, ack width 1 cycle.
- Back-to-back: addrs 0x0, 0x4, 0x8 holding 32'h00000093, 32'h00100113, 32'h00200193 -> three acks in order, 5 cycles apart (LATENCY=3), correct data each.
- Redirect: req 0x10, then after 1 BUSY cycle change the addr to 0x40 -> exactly one ack, carrying store[16], LATENCY edges after the change.
- Withdraw and hold: drop req mid-BUSY -> no ack and return to IDLE. Hold i_hold=1 for 4 BUSY cycles -> ack delayed by exactly 4 cycles.
- Errors: req 0x6 -> ack with err=1, data 32'h00000013. Req (DEPTH_WORDS*4) -> err=1, NOP. Same-edge write and read to the target word -> old data returned, new data on the next fetch.
